mult_seq: RTL



---
 rtl/mult_seq_if.sv | 25 ++
 rtl/mult_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mult_seq_if.sv
// mult_seq_if: operand/result bundle for the sequential multiplier.
// The master drives the start request and operands; the slave (multiplier)
// returns busy, the completion strobe and the two product halves.
interface mult_seq_if #(
   parameter int WIDTH = 8
);
   logic             activate;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             is_signed;
   logic             busy;
   logic             endop;
   logic [WIDTH-1:0] mult8;
   logic [WIDTH-1:0] mult16;

   modport master (
      output activate, in1, in2, is_signed,
      input  busy, endop, mult8, mult16
   );

   modport slave (
      input  activate, in1, in2, is_signed,
      output busy, endop, mult8, mult16
   );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: sequential shift-and-add multiplier, one multiplier bit per clock.
// Product (2*WIDTH bits) is returned as mult16 (high) / mult8 (low) with a
// one-cycle endop strobe, and held until the next completion.
// Optional feature: define MULT_SEQ_SIGNED_EN to honour is_signed (two's
// complement operands, corrected by magnitude-then-negate). Without it,
// is_signed is ignored and all arithmetic is unsigned.
module mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic      clk,
   input  logic      reset,
   mult_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] acc_hi_reg;   // upper half of accumulator
   logic [WIDTH-1:0] acc_lo_reg;   // lower half; starts as the multiplier
   logic [WIDTH-1:0] mcand_reg;
   logic             busy_reg;
   logic             endop_reg;
   logic [WIDTH-1:0] mult8_reg;
   logic [WIDTH-1:0] mult16_reg;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] hi_next;
   logic [WIDTH-1:0] lo_next;
   logic [PW-1:0]    prod;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;

`ifdef MULT_SEQ_SIGNED_EN
   logic             neg_reg;      // final product must be negated
   logic             neg_in;

   // Operand magnitudes and result sign, evaluated at acceptance
   always_comb begin
      op1    = bus.in1;
      op2    = bus.in2;
      neg_in = 1'b0;
      if (bus.is_signed) begin
         if (bus.in1[WIDTH-1]) op1 = ~bus.in1 + WIDTH'(1);
         if (bus.in2[WIDTH-1]) op2 = ~bus.in2 + WIDTH'(1);
         neg_in = bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
      end
   end
`else
   // Unsigned build: operands are used as-is
   always_comb begin
      op1 = bus.in1;
      op2 = bus.in2;
   end
`endif

   // One shift-and-add step; the carry of the add enters the shifted word
   always_comb begin
      sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], acc_lo_reg[WIDTH-1:1]};
      prod    = {hi_next, lo_next};
`ifdef MULT_SEQ_SIGNED_EN
      if (neg_reg) prod = ~prod + PW'(1);
`endif
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         acc_hi_reg <= '0;
         acc_lo_reg <= '0;
         mcand_reg  <= '0;
         busy_reg   <= 1'b0;
         endop_reg  <= 1'b0;
         mult8_reg  <= '0;
         mult16_reg <= '0;
`ifdef MULT_SEQ_SIGNED_EN
         neg_reg    <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               endop_reg <= 1'b0;
               if (bus.activate) begin
                  acc_lo_reg <= op1;
                  mcand_reg  <= op2;
                  acc_hi_reg <= '0;
                  cnt_reg    <= '0;
                  busy_reg   <= 1'b1;
                  state_reg  <= RUN;
`ifdef MULT_SEQ_SIGNED_EN
                  neg_reg    <= neg_in;
`endif
               end
            end
            RUN: begin
               acc_hi_reg <= hi_next;
               acc_lo_reg <= lo_next;
               cnt_reg    <= cnt_reg + CW'(1);
               // Last iteration: the product is final, publish it with endop
               if (cnt_reg == CW'(WIDTH - 1)) begin
                  state_reg  <= DONE;
                  endop_reg  <= 1'b1;
                  mult8_reg  <= prod[WIDTH-1:0];
                  mult16_reg <= prod[PW-1:WIDTH];
               end
            end
            DONE: begin
               endop_reg <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               endop_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_reg;
   assign bus.endop  = endop_reg;
   assign bus.mult8  = mult8_reg;
   assign bus.mult16 = mult16_reg;
endmodule
